// File: rtl/prog_rd_scheduler.sv
// rtl/prog_rd_scheduler.sv - round-robin program read scheduler with packet data framing
module prog_rd_scheduler #(
    parameter int PROG_BIT_WIDTH = 8,
    parameter int TOTAL_PROG_NUM = 2 ** PROG_BIT_WIDTH,
    parameter int PKT_WORDS      = 12,
    parameter int TIMEOUT_CYC    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TOTAL_PROG_NUM-1:0] ddr_rd_data_req,
    output logic [TOTAL_PROG_NUM-1:0] ddr_rd_data_ack,
    output logic                      rd_cmd_valid,
    output logic [PROG_BIT_WIDTH-1:0] rd_cmd_prog,
    input  logic                      rd_cmd_ready,
    input  logic                      rd_data_valid,
    output logic [TOTAL_PROG_NUM-1:0] head_val,
    output logic                      memc_data_head_valid,
    output logic [15:0]               memc_rd_data_valid,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int WC_W = $clog2(PKT_WORDS);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [PROG_BIT_WIDTH-1:0] rr_ptr;
    logic [PROG_BIT_WIDTH-1:0] prog_reg;
    logic [PROG_BIT_WIDTH-1:0] grant_idx;
    logic [PROG_BIT_WIDTH-1:0] scan_idx;
    logic                      grant_found;
    logic [WC_W-1:0]           word_cnt;
    logic [TO_W-1:0]           to_cnt;
    logic [TOTAL_PROG_NUM-1:0] ack_reg;
    logic                      timeout_reg;
    logic                      data_word;
    logic                      head_word;
    logic                      last_word;
    logic                      to_hit;

    assign data_word = (state == DATA) & rd_data_valid;
    assign head_word = data_word & (word_cnt == '0);
    assign last_word = data_word & (word_cnt == WC_W'(PKT_WORDS - 1));
    assign to_hit    = (state == DATA) & ~rd_data_valid & (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Scan downward so the lowest offset above rr_ptr wins; offset N wraps to rr_ptr itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = TOTAL_PROG_NUM; i >= 1; i--) begin
            scan_idx = rr_ptr + PROG_BIT_WIDTH'(i);
            if (ddr_rd_data_req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_found) state_nxt = CMD;
            CMD:  if (rd_cmd_ready) state_nxt = DATA;
            DATA: if (last_word || to_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= PROG_BIT_WIDTH'(TOTAL_PROG_NUM - 1);
            prog_reg    <= '0;
            word_cnt    <= '0;
            to_cnt      <= '0;
            ack_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            ack_reg     <= '0;
            timeout_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) prog_reg <= grant_idx;
                end
                CMD: begin
                    if (rd_cmd_ready) begin
                        ack_reg[prog_reg] <= 1'b1;
                        rr_ptr            <= prog_reg;
                        word_cnt          <= '0;
                        to_cnt            <= '0;
                    end
                end
                DATA: begin
                    if (rd_data_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_hit) timeout_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Framing is combinational so it lines up with the data word on memc_data.
    always_comb begin
        head_val           = '0;
        memc_rd_data_valid = '0;
        head_val[prog_reg] = head_word;
        memc_rd_data_valid[prog_reg[PROG_BIT_WIDTH-1 -: 4]] = data_word;
    end

    assign memc_data_head_valid = head_word;
    assign ddr_rd_data_ack      = ack_reg;
    assign rd_cmd_valid         = (state == CMD);
    assign rd_cmd_prog          = prog_reg;
    assign busy                 = (state != IDLE);
    assign timeout_err          = timeout_reg;

endmodule

// File: tb/tb_prog_rd_scheduler.sv
// tb/tb_prog_rd_scheduler.sv - self-checking bench for prog_rd_scheduler
module tb_prog_rd_scheduler;

    localparam int PB      = 8;
    localparam int N       = 256;
    localparam int PKT     = 12;
    localparam int TO_CYC  = 1023;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   ack;
    logic           rd_cmd_valid;
    logic [PB-1:0]  rd_cmd_prog;
    logic           rd_cmd_ready;
    logic           rd_data_valid;
    logic [N-1:0]   head_val;
    logic           memc_data_head_valid;
    logic [15:0]    memc_rd_data_valid;
    logic           busy;
    logic           timeout_err;

    int checks;
    int failures;
    int exp_q[$];

    prog_rd_scheduler #(
        .PROG_BIT_WIDTH(PB),
        .TOTAL_PROG_NUM(N),
        .PKT_WORDS     (PKT),
        .TIMEOUT_CYC   (TO_CYC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ddr_rd_data_req     (req),
        .ddr_rd_data_ack     (ack),
        .rd_cmd_valid        (rd_cmd_valid),
        .rd_cmd_prog         (rd_cmd_prog),
        .rd_cmd_ready        (rd_cmd_ready),
        .rd_data_valid       (rd_data_valid),
        .head_val            (head_val),
        .memc_data_head_valid(memc_data_head_valid),
        .memc_rd_data_valid  (memc_rd_data_valid),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    typedef struct {
        int r0;
        int r1;
        int r2;
        int ready_dly;
        int nwords;
        int abort_at;
        bit reraise;
        int exp_prog;
        bit reset_before;
    } vec_t;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, ack, '0);
        chk({tag, "_cmd_valid"}, N'(rd_cmd_valid), '0);
        chk({tag, "_head_val"}, head_val, '0);
        chk({tag, "_head_or"}, N'(memc_data_head_valid), '0);
        chk({tag, "_data_valid"}, N'(memc_rd_data_valid), '0);
        chk({tag, "_busy"}, N'(busy), '0);
        chk({tag, "_timeout"}, N'(timeout_err), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        rd_cmd_ready = 1'b0;
        rd_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Requester + memory-controller model for one packet; expectation comes from the scoreboard.
    task automatic serve(input int nwords, input int ready_dly, input bit reraise, input int abort_at);
        int n;
        int k;
        logic [PB-1:0] p;
        logic [N-1:0] oh;
        logic [15:0] ch;
        rd_cmd_ready = 1'b0;
        n = 0;
        @(negedge clk); #1;
        while (rd_cmd_valid !== 1'b1 && n < 50) begin
            chk("ack_while_idle", ack, '0);
            @(negedge clk); #1;
            n++;
        end
        chk("cmd_wait", N'(rd_cmd_valid), N'(1));
        if (exp_q.size() == 0) begin
            chk("sb_underflow", N'(1), N'(0));
            return;
        end
        p = PB'(exp_q.pop_front());
        if (rd_cmd_valid !== 1'b1) return;
        oh = '0;
        oh[p] = 1'b1;
        ch = '0;
        ch[p[PB-1 -: 4]] = 1'b1;
        chk("cmd_prog", N'(rd_cmd_prog), N'(p));
        for (int i = 0; i < ready_dly; i++) begin
            chk("stall_valid", N'(rd_cmd_valid), N'(1));
            chk("stall_prog", N'(rd_cmd_prog), N'(p));
            chk("stall_ack", ack, '0);
            @(negedge clk); #1;
        end
        chk("accept_ack_pre", ack, '0);
        rd_cmd_ready = 1'b1;
        @(negedge clk);
        rd_cmd_ready = 1'b0;
        #1;
        chk("ack_onehot", ack, oh);
        chk("ack_cycle_cmd_valid", N'(rd_cmd_valid), '0);
        chk("ack_cycle_busy", N'(busy), N'(1));
        req[p] = 1'b0;
        @(negedge clk); #1;
        chk("ack_single_cycle", ack, '0);
        for (int w = 0; w < nwords; w++) begin
            if (w == abort_at) begin
                rst = 1'b1;
                rd_data_valid = 1'b1;
                #1;
                chk_all_zero("abort");
                return;
            end
            rd_data_valid = 1'b1;
            #1;
            chk("head_val", head_val, (w == 0) ? oh : '0);
            chk("head_or", N'(memc_data_head_valid), N'(w == 0));
            chk("chan_valid", N'(memc_rd_data_valid), N'(ch));
            @(negedge clk); #1;
        end
        rd_data_valid = 1'b0;
        if (reraise) req[p] = 1'b1;
        #1;
        if (nwords >= PKT) begin
            chk("busy_after_last", N'(busy), '0);
        end else begin
            k = 1;
            while (timeout_err !== 1'b1 && k < 1200) begin
                @(negedge clk); #1;
                k++;
            end
            chk("timeout_delay", N'(k), N'(TO_CYC + 1));
            chk("timeout_idle", N'(busy), '0);
            @(negedge clk);
            rd_data_valid = 1'b1;
            #1;
            chk("timeout_pulse_width", N'(timeout_err), '0);
            chk("stray_head", head_val, '0);
            chk("stray_head_or", N'(memc_data_head_valid), '0);
            chk("stray_valid", N'(memc_rd_data_valid), '0);
            rd_data_valid = 1'b0;
        end
    endtask

    vec_t vecs[10];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = '0;
        rd_cmd_ready = 1'b0;
        rd_data_valid = 1'b0;

        vecs[0] = '{5,   -1,  -1,  0, 12, -1, 1'b0, 5,   1'b0};
        vecs[1] = '{3,   200, 255, 0, 12, -1, 1'b1, 3,   1'b1};
        vecs[2] = '{-1,  -1,  -1,  0, 12, -1, 1'b1, 200, 1'b0};
        vecs[3] = '{-1,  -1,  -1,  0, 12, -1, 1'b1, 255, 1'b0};
        vecs[4] = '{-1,  -1,  -1,  0, 12, -1, 1'b0, 3,   1'b0};
        vecs[5] = '{-1,  -1,  -1,  0, 12, -1, 1'b0, 200, 1'b0};
        vecs[6] = '{-1,  -1,  -1,  0, 12, -1, 1'b0, 255, 1'b0};
        vecs[7] = '{9,   -1,  -1, 20, 12, -1, 1'b0, 9,   1'b0};
        vecs[8] = '{17,  -1,  -1,  0,  5, -1, 1'b0, 17,  1'b0};
        vecs[9] = '{40,  -1,  -1,  0, 12,  6, 1'b0, 40,  1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_cmd_prog", N'(rd_cmd_prog), '0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].reset_before) do_reset();
            if (vecs[v].r0 >= 0) req[vecs[v].r0] = 1'b1;
            if (vecs[v].r1 >= 0) req[vecs[v].r1] = 1'b1;
            if (vecs[v].r2 >= 0) req[vecs[v].r2] = 1'b1;
            exp_q.push_back(vecs[v].exp_prog);
            serve(vecs[v].nwords, vecs[v].ready_dly, vecs[v].reraise, vecs[v].abort_at);
        end

        // Still in reset from the aborted packet: everything must stay quiet.
        rd_data_valid = 1'b0;
        @(negedge clk); #1;
        chk_all_zero("in_reset");
        rst = 1'b0;
        req = '0;
        req[9] = 1'b1;
        req[0] = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(9);
        serve(PKT, 0, 1'b0, -1);
        serve(PKT, 0, 1'b0, -1);

        // Data strobes while idle must not produce framing.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_data_valid = (i % 2 == 0);
            #1;
            chk("idle_head", head_val, '0);
            chk("idle_head_or", N'(memc_data_head_valid), '0);
            chk("idle_valid", N'(memc_rd_data_valid), '0);
            chk("idle_busy", N'(busy), '0);
        end
        rd_data_valid = 1'b0;

        chk("sb_empty", N'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
